instruction_loader: RTL and testbench

- Boot-time writer for the instruction memory that the core fetches from.
- Receives a framed byte stream (from the UART/debug link) and assembles 16-bit instruction words.
- Writes those words sequentially into instruction RAM and holds the core in reset until a checksum-verified image is resident.
- Replaces the fixed ROM image as the program source when field-loadable code is required.

---
 rtl/instruction_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_instruction_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//
// Boot-time writer for the instruction RAM. It takes a framed byte stream from
// the UART/debug link, builds 16-bit instruction words and writes them to
// consecutive RAM addresses. The core is held in reset until a whole image,
// checksum included, has been received and verified.
//
// Frame: COUNT_LO, COUNT_HI (word count N), N x {WORD_LO, WORD_HI}, CHK.
// CHK is the modulo-256 sum of every byte before it, count bytes included.
//
// Ports
//   clk          system clock
//   async_rst_n  asynchronous active-low reset
//   ByteValid    input byte present
//   ByteData     input byte
//   ByteReady    loader can take a byte (a byte moves when Valid && Ready)
//   Start        one-cycle re-arm request, only honoured in DONE / ERROR
//   InstWrEn     instruction RAM write strobe (one cycle per word)
//   InstWrAddr   instruction RAM write address
//   InstWrData   instruction RAM write data
//   CoreHold     keeps the core in reset while high
//   LoadDone     image loaded and checksum verified
//   LoadError    frame rejected
//   ErrorCode    0 none, 1 checksum, 2 oversize, 3 timeout
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int START_ADDR     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  input  logic                  Start,
  output logic                  InstWrEn,
  output logic [ADDR_WIDTH-1:0] InstWrAddr,
  output logic [15:0]           InstWrData,
  output logic                  CoreHold,
  output logic                  LoadDone,
  output logic                  LoadError,
  output logic [1:0]            ErrorCode
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_OVERSIZE = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  // Largest word count that still fits between START_ADDR and the top of RAM.
  localparam int unsigned MAX_WORDS = (1 << ADDR_WIDTH) - START_ADDR;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0]         TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST    = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST     = '1;

  state_e                  state_q,   state_d;
  err_e                    err_q,     err_d;
  logic [7:0]              lo_q,      lo_d;      // count low byte / word low byte
  logic [7:0]              sum_q,     sum_d;     // running checksum
  logic [15:0]             count_q,   count_d;   // words still to be written
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [15:0]             wdata_q,   wdata_d;
  logic [TW-1:0]           timer_q,   timer_d;
  logic                    started_q, started_d;

  logic        accept;
  logic        timed;
  logic        timeout_hit;
  logic [15:0] count_n;

  assign ByteReady = state_q inside {S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CHECK};
  assign accept    = ByteValid && ByteReady;
  assign count_n   = {ByteData, lo_q};

  // Idle timer only runs while a frame is in flight and a byte is expected.
  assign timed       = started_q && (state_q inside {S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CHECK});
  // A byte arriving on the limit cycle wins, hence the !accept term.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && timed && !accept && (timer_q == TIMEOUT_LIMIT);

  // NOTE: every register is driven with <= here so all state updates see the
  // pre-edge values, whatever order the simulator evaluates processes in.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= S_CNT_LO;
      err_q     <= ERR_NONE;
      lo_q      <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      addr_q    <= ADDR_FIRST;
      wdata_q   <= '0;
      timer_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      lo_q      <= lo_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    // NOTE: each _d starts as a copy of its _q so no path through the case
    // below leaves a signal unassigned, which would infer a latch.
    state_d   = state_q;
    err_d     = err_q;
    lo_d      = lo_q;
    sum_d     = sum_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    started_d = started_q;

    if (accept) begin
      timer_d = '0;
    end else if (timed && (timer_q != TIMEOUT_LIMIT)) begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      S_CNT_LO: begin
        if (accept) begin
          lo_d      = ByteData;
          sum_d     = sum_q + ByteData;
          started_d = 1'b1;
          state_d   = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (accept) begin
          sum_d = sum_q + ByteData;
          if ({16'd0, count_n} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = ERR_OVERSIZE;
          end else if (count_n == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            count_d = count_n;
            state_d = S_DATA_LO;
          end
        end
      end

      S_DATA_LO: begin
        if (accept) begin
          lo_d    = ByteData;
          sum_d   = sum_q + ByteData;
          state_d = S_DATA_HI;
        end
      end

      S_DATA_HI: begin
        if (accept) begin
          wdata_d = {ByteData, lo_q};
          sum_d   = sum_q + ByteData;
          state_d = S_WRITE;
        end
      end

      // Strobe cycle: address holds during the strobe and advances after it.
      // The oversize check means a write at ADDR_LAST is always the last one,
      // so holding there keeps the address from wrapping.
      S_WRITE: begin
        count_d = count_q - 16'd1;
        if (addr_q != ADDR_LAST) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
        state_d = (count_q == 16'd1) ? S_CHECK : S_DATA_LO;
      end

      S_CHECK: begin
        if (accept) begin
          if (ByteData == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CHECKSUM;
          end
        end
      end

      S_DONE, S_ERROR: begin
        if (Start) begin
          state_d   = S_CNT_LO;
          err_d     = ERR_NONE;
          sum_d     = '0;
          count_d   = '0;
          addr_d    = ADDR_FIRST;
          timer_d   = '0;
          started_d = 1'b0;
        end
      end

      default: state_d = S_CNT_LO;
    endcase

    if (timeout_hit) begin
      state_d = S_ERROR;
      err_d   = ERR_TIMEOUT;
    end
  end

  assign InstWrEn   = (state_q == S_WRITE);
  assign InstWrAddr = addr_q;
  assign InstWrData = wdata_q;
  assign CoreHold   = (state_q != S_DONE);
  assign LoadDone   = (state_q == S_DONE);
  assign LoadError  = (state_q == S_ERROR);
  assign ErrorCode  = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// -----------------------------------------------------------------------------
// tb_instruction_loader
//
// Self-checking bench for instruction_loader. Frames are described by a word
// count and a list of words; a frame-level model turns that into the byte
// stream and the expected RAM writes and final status. A negedge monitor logs
// every write strobe so the log can be compared with the model afterwards.
// -----------------------------------------------------------------------------
module tb_instruction_loader;

  localparam int AW    = 10;
  localparam int SA    = 0;
  localparam int TO    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          async_rst_n;
  logic          ByteValid;
  logic [7:0]    ByteData;
  logic          ByteReady;
  logic          Start;
  logic          InstWrEn;
  logic [AW-1:0] InstWrAddr;
  logic [15:0]   InstWrData;
  logic          CoreHold;
  logic          LoadDone;
  logic          LoadError;
  logic [1:0]    ErrorCode;

  instruction_loader #(
    .ADDR_WIDTH    (AW),
    .START_ADDR    (SA),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .ByteValid  (ByteValid),
    .ByteData   (ByteData),
    .ByteReady  (ByteReady),
    .Start      (Start),
    .InstWrEn   (InstWrEn),
    .InstWrAddr (InstWrAddr),
    .InstWrData (InstWrData),
    .CoreHold   (CoreHold),
    .LoadDone   (LoadDone),
    .LoadError  (LoadError),
    .ErrorCode  (ErrorCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  wr_t        wr_log[$];
  wr_t        exp_wr[$];
  logic [7:0] frame_q[$];
  int         word_q[$];
  bit         exp_done;
  bit         exp_err;
  int         exp_code;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  always @(negedge clk) begin
    if (InstWrEn === 1'b1) wr_log.push_back('{int'(InstWrAddr), int'(InstWrData)});
  end

  // Frame-level model. chk_mode: 0 correct CHK, 1 CHK forced to 0x00,
  // 2 CHK corrupted by a random nonzero xor.
  task automatic model_frame(input int n, input int chk_mode);
    logic [7:0] sum;
    logic [7:0] chk;
    int         w;
    frame_q.delete();
    exp_wr.delete();
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    if (n > DEPTH - SA) begin
      exp_done = 0;
      exp_err  = 1;
      exp_code = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = word_q[i];
      frame_q.push_back(w[7:0]);
      frame_q.push_back(w[15:8]);
      exp_wr.push_back('{SA + i, w & 16'hFFFF});
    end
    sum = 8'd0;
    foreach (frame_q[i]) sum = sum + frame_q[i];
    case (chk_mode)
      0:       chk = sum;
      1:       chk = 8'h00;
      default: chk = sum ^ 8'($urandom_range(1, 255));
    endcase
    frame_q.push_back(chk);
    exp_done = (chk == sum);
    exp_err  = !exp_done;
    exp_code = exp_done ? 0 : 1;
  endtask

  // Sends one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) begin
      @(negedge clk);
      ByteValid = 1'b0;
    end
    @(negedge clk);
    ByteValid = 1'b1;
    ByteData  = b;
    budget    = 0;
    while (!ByteReady && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!ByteReady) check("byte_ready_wait", 32'(ByteReady), 32'd1);
    @(posedge clk);
    #1;
    ByteValid = 1'b0;
  endtask

  task automatic check_outcome(input string tag);
    check({tag, "_wr_count"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    foreach (exp_wr[i]) begin
      if (i < wr_log.size()) begin
        check({tag, "_wr_addr"}, 32'(wr_log[i].addr), 32'(exp_wr[i].addr));
        check({tag, "_wr_data"}, 32'(wr_log[i].data), 32'(exp_wr[i].data));
      end
    end
    check({tag, "_done"},  32'(LoadDone),  32'(exp_done));
    check({tag, "_error"}, 32'(LoadError), 32'(exp_err));
    check({tag, "_code"},  32'(ErrorCode), 32'(exp_code));
    check({tag, "_hold"},  32'(CoreHold),  32'(!exp_done));
    check({tag, "_ready"}, 32'(ByteReady), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    wr_log.delete();
    foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
    check_outcome(tag);
  endtask

  task automatic rearm(input string tag);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    check({tag, "_rearm_ready"}, 32'(ByteReady),  32'd1);
    check({tag, "_rearm_addr"},  32'(InstWrAddr), 32'(SA));
    check({tag, "_rearm_done"},  32'(LoadDone),   32'd0);
    check({tag, "_rearm_err"},   32'(LoadError),  32'd0);
    check({tag, "_rearm_code"},  32'(ErrorCode),  32'd0);
    check({tag, "_rearm_hold"},  32'(CoreHold),   32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ByteReady),  32'd1);
    check({tag, "_wren"},  32'(InstWrEn),   32'd0);
    check({tag, "_addr"},  32'(InstWrAddr), 32'(SA));
    check({tag, "_data"},  32'(InstWrData), 32'd0);
    check({tag, "_hold"},  32'(CoreHold),   32'd1);
    check({tag, "_done"},  32'(LoadDone),   32'd0);
    check({tag, "_err"},   32'(LoadError),  32'd0);
    check({tag, "_code"},  32'(ErrorCode),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int k;
    async_rst_n = 1'b0;
    ByteValid   = 1'b0;
    ByteData    = 8'h00;
    Start       = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    async_rst_n = 1'b1;

    // Start outside DONE/ERROR is ignored.
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("start_ignored_ready", 32'(ByteReady), 32'd1);
    check("start_ignored_hold",  32'(CoreHold),  32'd1);

    // Three-word image.
    word_q = '{32'hD188, 32'hC220, 32'hE200};
    model_frame(3, 0);
    run_frame("n3", 0);
    rearm("n3");

    // Empty image.
    word_q.delete();
    model_frame(0, 0);
    run_frame("n0", 2);
    rearm("n0");

    // Bad checksum: writes still happen, frame rejected.
    word_q = '{32'hD188, 32'hC220, 32'hE200};
    model_frame(3, 1);
    run_frame("badchk", 1);
    rearm("badchk");

    // Oversize by one word.
    model_frame(DEPTH - SA + 1, 0);
    run_frame("oversize", 0);
    rearm("oversize");

    // Largest legal image: last write lands at the top address.
    word_q.delete();
    for (int i = 0; i < DEPTH - SA; i++) word_q.push_back(int'($urandom_range(0, 16'hFFFF)));
    model_frame(DEPTH - SA, 0);
    run_frame("full", 0);
    rearm("full");

    // Timeout: idle after the first data byte.
    word_q = '{32'hD188, 32'hC220, 32'hE200};
    model_frame(3, 0);
    wr_log.delete();
    for (int i = 0; i < 3; i++) send_byte(frame_q[i], 0);
    repeat (TO) @(posedge clk);
    #1;
    check("timeout_at_limit_err", 32'(LoadError), 32'd0);
    @(posedge clk);
    #1;
    check("timeout_err",  32'(LoadError), 32'd1);
    check("timeout_code", 32'(ErrorCode), 32'd3);
    check("timeout_hold", 32'(CoreHold),  32'd1);
    check("timeout_wr",   32'(wr_log.size()), 32'd0);
    rearm("timeout");

    // Idle gap just below the limit: frame completes.
    wr_log.delete();
    foreach (frame_q[i]) send_byte(frame_q[i], (i == 3) ? TO - 1 : 0);
    check_outcome("gap7");
    rearm("gap7");

    // Asynchronous reset after two of three words.
    word_q = '{32'h1234, 32'hABCD, 32'h5A5A};
    model_frame(3, 0);
    wr_log.delete();
    for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
    k = 0;
    while (wr_log.size() < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("midrst_two_writes", 32'(wr_log.size()), 32'd2);
    @(negedge clk);
    #2;
    async_rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    async_rst_n = 1'b1;
    word_q = '{32'h0F0F, 32'hF00D, 32'hBEEF};
    model_frame(3, 0);
    run_frame("after_rst", 1);
    rearm("after_rst");

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      int n;
      int mode;
      n = $urandom_range(0, 6);
      word_q.delete();
      for (int i = 0; i < n; i++) word_q.push_back(int'($urandom_range(0, 16'hFFFF)));
      mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      model_frame(n, mode);
      run_frame($sformatf("rand%0d", f), 4);
      rearm($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
